// File: rtl/arb_queue_pkg.sv
// Shared types and helpers for the arbitrated request queues.
// Source tags and the pointer-width helper used by the per-source FIFOs.
package arb_queue_pkg;

  typedef logic [0:0] src_t;

  localparam src_t SRC0 = 1'b0;
  localparam src_t SRC1 = 1'b1;

  // A single-entry FIFO still needs one pointer bit so the vectors stay legal.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with a combinational head-word read.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo
  import arb_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arb_request_queues.sv
// Two per-source FIFOs feeding one registered output stream, with requests
// to an external arbiter and its same-cycle grants selecting what is popped.
module arb_request_queues
  import arb_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic [1:0]       requests,
  input  logic [1:0]       grants,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output src_t             out_src,
  input  logic             out_ready,
  output logic             err
);

  logic [WIDTH-1:0] head0;
  logic [WIDTH-1:0] head1;
  logic             full0;
  logic             full1;
  logic             empty0;
  logic             empty1;
  logic             slot_free;
  logic             both_granted;
  logic             grant_bad;
  logic             pop0;
  logic             pop1;

  assign in0_ready = !full0;
  assign in1_ready = !full1;

  // A request is only raised when the output register can take the word now.
  assign slot_free    = !out_valid || out_ready;
  assign requests     = {!empty1 && slot_free, !empty0 && slot_free};
  assign both_granted = (grants == 2'b11);
  assign grant_bad    = both_granted ||
                        (grants[0] && !requests[0]) ||
                        (grants[1] && !requests[1]);
  assign pop0         = grants[0] && requests[0] && !both_granted;
  assign pop1         = grants[1] && requests[1] && !both_granted;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (in0_valid),
    .din   (in0_data),
    .pop   (pop0),
    .dout  (head0),
    .full  (full0),
    .empty (empty0)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (in1_valid),
    .din   (in1_data),
    .pop   (pop1),
    .dout  (head1),
    .full  (full1),
    .empty (empty1)
  );

  // A pop reloads the register even while it drains, giving one word per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC0;
      err       <= 1'b0;
    end else begin
      if (pop0) begin
        out_valid <= 1'b1;
        out_data  <= head0;
        out_src   <= SRC0;
      end else if (pop1) begin
        out_valid <= 1'b1;
        out_data  <= head1;
        out_src   <= SRC1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (grant_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_request_queues.sv
// Bench for arb_request_queues: a round-robin arbiter model closes the grant
// loop, and a queue-based reference model checks every cycle.
module tb_arb_request_queues;
  import arb_queue_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in0_valid, in1_valid, in0_ready, in1_ready;
  logic [WIDTH-1:0] in0_data, in1_data, out_data;
  logic [1:0]       requests, grants, forcedGrants, rrGrants;
  logic             out_valid, out_ready, err;
  src_t             out_src;
  logic             forceGrant;
  logic             lastSrc;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic             mValid;
  logic [WIDTH-1:0] mData;
  logic             mSrc;
  logic             mErr;

  typedef struct {
    bit             rstBefore;
    bit             hold;
    bit             v0;
    logic [WIDTH-1:0] d0;
    bit             v1;
    logic [WIDTH-1:0] d1;
    bit             ordy;
    bit             eValid;
    logic [WIDTH-1:0] eData;
    bit             eSrc;
  } vec_t;

  vec_t vecs[12];
  logic [WIDTH-1:0] seen[$];

  arb_request_queues #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .requests  (requests),
    .grants    (grants),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Two-requester round-robin arbiter; after reset source 0 wins a tie.
  always_comb begin
    rrGrants = 2'b00;
    case (requests)
      2'b01:   rrGrants = 2'b01;
      2'b10:   rrGrants = 2'b10;
      2'b11:   rrGrants = lastSrc ? 2'b01 : 2'b10;
      default: rrGrants = 2'b00;
    endcase
  end

  assign grants = forceGrant ? forcedGrants : rrGrants;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lastSrc <= 1'b1;
    else if (!forceGrant && ((grants & requests) != 2'b00)) lastSrc <= grants[1];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v0, input logic [WIDTH-1:0] d0,
                               input bit v1, input logic [WIDTH-1:0] d1,
                               input bit ordy);
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = ordy;
  endtask

  // Starts at posedge+1; checks combinational outputs, advances the model
  // across the next edge and checks registered outputs at posedge+1.
  task automatic stepCycle();
    bit       r0, r1, bad;
    bit [1:0] mReq, g;
    #4;
    r0      = q0.size() < DEPTH;
    r1      = q1.size() < DEPTH;
    mReq[0] = (q0.size() != 0) && (!mValid || out_ready);
    mReq[1] = (q1.size() != 0) && (!mValid || out_ready);
    checkOutput("requests", 32'(requests), 32'(mReq));
    checkOutput("in0_ready", 32'(in0_ready), 32'(r0));
    checkOutput("in1_ready", 32'(in1_ready), 32'(r1));
    g   = grants;
    bad = (g == 2'b11) || (g[0] && !mReq[0]) || (g[1] && !mReq[1]);
    if (g == 2'b01 && mReq[0]) begin
      mValid = 1'b1; mData = q0.pop_front(); mSrc = 1'b0;
    end else if (g == 2'b10 && mReq[1]) begin
      mValid = 1'b1; mData = q1.pop_front(); mSrc = 1'b1;
    end else if (out_ready) begin
      mValid = 1'b0;
    end
    if (bad) mErr = 1'b1;
    if (in0_valid && r0) q0.push_back(in0_data);
    if (in1_valid && r1) q1.push_back(in1_data);
    @(posedge clk);
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    checkOutput("err", 32'(err), 32'(mErr));
    if (mValid) begin
      checkOutput("out_data", 32'(out_data), 32'(mData));
      checkOutput("out_src", 32'(out_src), 32'(mSrc));
    end
  endtask

  // Asserts reset away from any edge and checks that it acts immediately.
  task automatic doReset();
    forceGrant   = 1'b0;
    forcedGrants = 2'b00;
    applyStimulus(0, '0, 0, '0, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_requests", 32'(requests), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_src", 32'(out_src), 32'd0);
    checkOutput("rst_ready", 32'({in1_ready, in0_ready}), 32'd3);
    q0.delete();
    q1.delete();
    mValid = 1'b0; mData = '0; mSrc = 1'b0; mErr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    forceGrant = 1'b0;
    forcedGrants = 2'b00;
    applyStimulus(0, '0, 0, '0, 0);

    // rst hold v0 d0 v1 d1 ordy | eValid eData eSrc
    vecs[0]  = '{1, 0, 1, 8'hA1, 0, 8'h00, 1, 0, 8'h00, 0};
    vecs[1]  = '{0, 0, 1, 8'hA2, 0, 8'h00, 1, 1, 8'hA1, 0};
    vecs[2]  = '{0, 0, 1, 8'hA3, 0, 8'h00, 1, 1, 8'hA2, 0};
    vecs[3]  = '{0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hA3, 0};
    vecs[4]  = '{0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0};
    vecs[5]  = '{1, 1, 1, 8'hA1, 1, 8'hB1, 0, 0, 8'h00, 0};
    vecs[6]  = '{0, 1, 1, 8'hA2, 1, 8'hB2, 0, 0, 8'h00, 0};
    vecs[7]  = '{0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hA1, 0};
    vecs[8]  = '{0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hB1, 1};
    vecs[9]  = '{0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hA2, 0};
    vecs[10] = '{0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hB2, 1};
    vecs[11] = '{0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0};

    #2;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rstBefore) doReset();
      forceGrant   = vecs[i].hold;
      forcedGrants = 2'b00;
      applyStimulus(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
      stepCycle();
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].eValid));
      if (vecs[i].eValid) begin
        checkOutput($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].eData));
        checkOutput($sformatf("vec%0d_src", i), 32'(out_src), 32'(vecs[i].eSrc));
      end
    end

    $display("[TB] backpressure");
    doReset();
    forceGrant = 1'b1;
    applyStimulus(1, 8'h11, 1, 8'h21, 0); stepCycle();
    applyStimulus(1, 8'h12, 1, 8'h22, 0); stepCycle();
    forceGrant = 1'b0;
    applyStimulus(0, '0, 0, '0, 0); stepCycle();
    checkOutput("bp_first", 32'(out_data), 32'h11);
    repeat (5) begin
      stepCycle();
      checkOutput("bp_requests", 32'(requests), 32'd0);
      checkOutput("bp_hold", 32'(out_data), 32'h11);
    end
    applyStimulus(0, '0, 0, '0, 1);
    seen.delete();
    repeat (3) begin
      stepCycle();
      if (out_valid) seen.push_back(out_data);
    end
    checkOutput("bp_count", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      checkOutput("bp_order0", 32'(seen[0]), 32'h21);
      checkOutput("bp_order1", 32'(seen[1]), 32'h12);
      checkOutput("bp_order2", 32'(seen[2]), 32'h22);
    end
    stepCycle();
    checkOutput("bp_drained", 32'(out_valid), 32'd0);

    $display("[TB] full fifo");
    doReset();
    forceGrant = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(0, '0, 1, WIDTH'(8'hC0 + k), 0);
      stepCycle();
    end
    checkOutput("full_ready", 32'(in1_ready), 32'd0);
    applyStimulus(0, '0, 1, 8'hC4, 0); stepCycle();
    checkOutput("full_still", 32'(in1_ready), 32'd0);
    forceGrant = 1'b0;
    applyStimulus(0, '0, 0, '0, 1); stepCycle();
    checkOutput("full_restored", 32'(in1_ready), 32'd1);
    checkOutput("full_head", 32'(out_data), 32'hC0);
    repeat (5) stepCycle();

    $display("[TB] protocol error");
    doReset();
    forceGrant = 1'b1;
    applyStimulus(1, 8'h31, 1, 8'h41, 0); stepCycle();
    forcedGrants = 2'b11;
    applyStimulus(0, '0, 0, '0, 0); stepCycle();
    checkOutput("perr_both_err", 32'(err), 32'd1);
    checkOutput("perr_no_pop", 32'(out_valid), 32'd0);
    checkOutput("perr_counts", 32'(requests), 32'd3);
    forcedGrants = 2'b00;
    forceGrant   = 1'b0;
    applyStimulus(0, '0, 0, '0, 1);
    repeat (4) stepCycle();
    forceGrant   = 1'b1;
    forcedGrants = 2'b01;
    stepCycle();
    forcedGrants = 2'b00;
    repeat (2) begin
      stepCycle();
      checkOutput("perr_sticky", 32'(err), 32'd1);
    end

    $display("[TB] reset mid-stream");
    applyStimulus(0, '0, 0, '0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1, WIDTH'(8'h51 + k), 0, '0, 0);
      stepCycle();
    end
    forceGrant = 1'b0;
    applyStimulus(0, '0, 0, '0, 0); stepCycle();
    checkOutput("mid_valid_before", 32'(out_valid), 32'd1);
    doReset();
    applyStimulus(1, 8'h61, 0, '0, 1); stepCycle();
    applyStimulus(0, '0, 0, '0, 1);
    seen.delete();
    repeat (4) begin
      stepCycle();
      if (out_valid) seen.push_back(out_data);
    end
    checkOutput("mid_count", 32'(seen.size()), 32'd1);
    if (seen.size() == 1) checkOutput("mid_word", 32'(seen[0]), 32'h61);

    $display("[TB] random traffic");
    doReset();
    for (int n = 0; n < 400; n++) begin
      forceGrant   = ($urandom_range(0, 7) == 0);
      forcedGrants = 2'b00;
      applyStimulus(bit'($urandom_range(0, 1)), WIDTH'($urandom),
                    bit'($urandom_range(0, 1)), WIDTH'($urandom),
                    ($urandom_range(0, 3) != 0));
      stepCycle();
    end
    forceGrant = 1'b0;
    applyStimulus(0, '0, 0, '0, 1);
    repeat (2 * DEPTH + 2) stepCycle();
    checkOutput("rand_drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_request_queues.md
# arb_request_queues

Upstream/downstream companion of the two-requester round-robin arbiter. Buffers two independent valid/ready input streams in per-source FIFOs and raises `requests[i]` while source i has data and the output can accept it. It pops the source selected by `grants` from the arbiter and registers the popped word onto a single valid/ready output stream tagged with its source. The arbiter's combinational `grants` close the loop in the same cycle.

## Interface
- `WIDTH`, 8: data width of each stream.
- `DEPTH`, 4: entries per source FIFO; power of two, ≥ 2.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (assert 0 = reset).
- `in0_valid` / `in1_valid`  in  1  source word offered.
- `in0_data` / `in1_data`  in  WIDTH  source word.
- `in0_ready` / `in1_ready`  out  1  FIFO not full.
- `requests`  out  2  to arbiter; bit i = FIFO i non-empty AND output slot free.
- `grants`  in  2  from arbiter; expected one-hot or 00, same cycle as `requests`.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  WIDTH  granted word.
- `out_src`  out  1  source index of `out_data`.
- `out_ready`  in  1  downstream accepts.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Push i: `ini_valid & ini_ready` writes `ini_data` at tail; `ini_ready = !full_i`. There is no same-cycle pass-through when full, even if a pop occurs.
- Slot free: `slot_free = !out_valid | out_ready`.
- Requests: `requests[i] = !empty_i & slot_free`, combinational.
- Pop: `pop_i = grants[i] & requests[i] & !(grants == 2'b11)`. The head word is read, the pointer advances, and on the same edge the output register loads `{data, src=i}` with `out_valid = 1`.
- Output drain: `out_valid & out_ready` with no pop clears `out_valid`. Drain and pop in the same cycle keeps `out_valid = 1` with the new word (full throughput, one word per cycle).
- Error: `err` sets (sticky until reset) on either of these, and no pop occurs:
  - `grants == 2'b11`;
  - `grants[i] = 1` while `requests[i] = 0`.
- Simultaneous push and pop on the same non-full FIFO: both occur and the count is unchanged.
- Empty FIFO: `requests[i] = 0`. A pushed word raises the request the cycle after the push edge.
- Pointer wrap-around: `log2(DEPTH)`-bit pointers plus `log2(DEPTH)+1`-bit count. Full = count == DEPTH; empty = count == 0.

## Timing
- Reset values:
  - `out_valid = 0`, `out_data = 0`, `out_src = 0`, `err = 0`;
  - counts and pointers 0, so `requests = 00` and `in0_ready = in1_ready = 1`.
- Reset asserted mid-operation discards all buffered words immediately (asynchronous). No output word survives.
- Latency:
  - input accept edge → request visible: next cycle;
  - grant cycle → `out_valid` with word: next cycle.
- Minimum input-to-output latency is 2 cycles. Throughput is 1 word/cycle aggregate.
- `out_data` and `out_src` are stable while `out_valid & !out_ready`.
- All outputs are registered except `requests` and `ini_ready`, which are combinational from state and `out_ready`.

## Structure
- Package `arb_queue_pkg`:
  - `typedef logic [0:0] src_t`;
  - localparams `SRC0 = 1'b0`, `SRC1 = 1'b1`;
  - function `ptr_w(depth)` returning the pointer width.
- Sub-module `sync_fifo` (params WIDTH, DEPTH; ports clk, rst, push, din, pop, dout, full, empty), instantiated twice with head-word read combinationally.
- Top level holds request/pop logic, output register and error flag.

## Test plan
Bench connects `round_robin_arbiter_with_2_requests` (reset adapted to active-low) to `requests`/`grants`.
- Single source: push A1,A2,A3 on in0, `out_ready = 1` → out `A1,A2,A3`, `out_src = 0,0,0`, first `out_valid` 2 cycles after the A1 accept.
- Alternation: preload in0 = {A1,A2}, in1 = {B1,B2}, then `out_ready = 1` → out order A1,B1,A2,B2 (round-robin), one word per cycle.
- Backpressure: `out_ready = 0` for 5 cycles with both FIFOs non-empty:
  - `requests = 00`;
  - `out_data` holds its value;
  - no pop;
  - on release, the sequence resumes with no loss or duplication.
- Full: push DEPTH = 4 words to in1 with no grants → `in1_ready = 0` after the 4th. A 5th `valid` is not accepted. Popping one restores `in1_ready` the next cycle.
- Protocol error:
  - force `grants = 11` → `err = 1`, no pop, FIFO counts unchanged;
  - force `grants = 01` with FIFO0 empty → `err` stays 1 until reset.
- Reset mid-stream: `rst = 0` with 3 words buffered and `out_valid = 1` → immediately `out_valid = 0`, `requests = 00`, `err = 0`. After release, only newly pushed words appear.
